// File: rtl/multi_gate_watchdog_pkg.sv
// Shared constants and helpers for the multi-channel gate-activity watchdog.
package multi_gate_watchdog_pkg;

  // IAGC status encoding in which monitoring is active.
  localparam int unsigned IAGC_STATUS_IDLE = 2;  // 4'b0010

  // Ceiling log2: the number of bits needed to index v distinct values.
  function automatic int unsigned clog2_f(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

endpackage : multi_gate_watchdog_pkg

// File: rtl/multi_gate_watchdog_gate_channel_monitor.sv
// One watchdog channel: saturating activity counter, consecutive-miss counter
// and the registered health bit. Build macro WDOG_EDGE_EN selects rising-edge
// activity counting instead of high-level cycle counting.
module gate_channel_monitor
  import multi_gate_watchdog_pkg::*;
#(
  parameter int unsigned MIN_PULSES = 1,
  parameter int unsigned MISS_LIMIT = 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic eval_i,
  input  logic gate_i,
  output logic valid_o,
  output logic valid_nxt_c
);

  localparam int unsigned AW = clog2_f(MIN_PULSES + 1);
  localparam int unsigned MW = clog2_f(MISS_LIMIT + 1);

  logic          unit_c;
  logic [AW-1:0] act_q, act_d, act_sum_c;
  logic [MW-1:0] miss_q, miss_d, miss_inc_c;
  logic          valid_q, valid_d;

`ifdef WDOG_EDGE_EN
  logic gate_q;

  // Delayed gate copy for rising-edge detection; tracks the gate even in HOLD.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) gate_q <= 1'b0;
    else         gate_q <= gate_i;
  end

  assign unit_c = gate_i & ~gate_q;
`else
  assign unit_c = gate_i;
`endif

  // Window accounting and health decision at the evaluation strobe.
  always_comb begin
    act_sum_c  = (act_q == AW'(MIN_PULSES)) ? act_q : act_q + AW'(unit_c);
    miss_inc_c = (miss_q == MW'(MISS_LIMIT)) ? miss_q : miss_q + MW'(1);
    act_d      = act_q;
    miss_d     = miss_q;
    valid_d    = valid_q;
    if (!en_i) begin
      act_d   = '0;
      miss_d  = '0;
      valid_d = 1'b1;
    end else if (eval_i) begin
      act_d = '0;
      if (act_sum_c >= AW'(MIN_PULSES)) begin
        miss_d  = '0;
        valid_d = 1'b1;
      end else begin
        miss_d = miss_inc_c;
        if (miss_inc_c == MW'(MISS_LIMIT)) valid_d = 1'b0;
      end
    end else begin
      act_d = act_sum_c;
    end
  end

  // Channel state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      act_q   <= '0;
      miss_q  <= '0;
      valid_q <= 1'b1;
    end else begin
      act_q   <= act_d;
      miss_q  <= miss_d;
      valid_q <= valid_d;
    end
  end

  assign valid_o     = valid_q;
  assign valid_nxt_c = valid_d;

endmodule : gate_channel_monitor

// File: rtl/multi_gate_watchdog.sv
// Per-channel gate-activity watchdog for the IAGC datapath. Shared window
// counter, sticky fault and all-valid summary live here; per-channel state is
// in gate_channel_monitor. Build macro WDOG_EDGE_EN: count rising edges rather
// than high cycles.
module multi_gate_watchdog
  import multi_gate_watchdog_pkg::*;
#(
  parameter int unsigned IAGC_STATUS_SIZE = 4,
  parameter int unsigned NUM_CHANNELS     = 4,
  parameter int unsigned TICKS            = 120000000,
  parameter int unsigned MIN_PULSES       = 1,
  parameter int unsigned MISS_LIMIT       = 1
) (
  input  logic                        i_clock,
  input  logic                        i_resetN,
  input  logic [IAGC_STATUS_SIZE-1:0] i_iagcStatus,
  input  logic [NUM_CHANNELS-1:0]     i_gate,
  input  logic                        i_clearFault,
  output logic [NUM_CHANNELS-1:0]     o_valid,
  output logic                        o_allValid,
  output logic                        o_fault,
  output logic                        o_windowTick
);

  localparam int unsigned TW = clog2_f(TICKS);

  logic                    enable_c, eval_c;
  logic [TW-1:0]           win_q, win_d;
  logic                    tick_q, fault_q, fault_d, all_q;
  logic [NUM_CHANNELS-1:0] valid_q, valid_nxt_c;

  assign enable_c = (i_iagcStatus == IAGC_STATUS_SIZE'(IAGC_STATUS_IDLE));
  assign eval_c   = enable_c && (win_q == TW'(TICKS - 1));

  // Window counter: held at 0 outside IDLE, wraps after the evaluation cycle.
  always_comb begin
    win_d = '0;
    if (enable_c && !eval_c) win_d = win_q + TW'(1);
  end

  // Sticky fault: any health bit falling sets it, and a set beats a clear.
  always_comb begin
    fault_d = fault_q;
    if (i_clearFault) fault_d = 1'b0;
    if (|(valid_q & ~valid_nxt_c)) fault_d = 1'b1;
  end

  // Shared registers.
  always_ff @(posedge i_clock or negedge i_resetN) begin
    if (!i_resetN) begin
      win_q   <= '0;
      tick_q  <= 1'b0;
      fault_q <= 1'b0;
      all_q   <= 1'b1;
    end else begin
      win_q   <= win_d;
      tick_q  <= eval_c;
      fault_q <= fault_d;
      all_q   <= &valid_nxt_c;
    end
  end

  for (genvar ch = 0; ch < NUM_CHANNELS; ch++) begin : g_ch
    gate_channel_monitor #(
      .MIN_PULSES(MIN_PULSES),
      .MISS_LIMIT(MISS_LIMIT)
    ) u_mon (
      .clk_i      (i_clock),
      .rst_ni     (i_resetN),
      .en_i       (enable_c),
      .eval_i     (eval_c),
      .gate_i     (i_gate[ch]),
      .valid_o    (valid_q[ch]),
      .valid_nxt_c(valid_nxt_c[ch])
    );
  end

  assign o_valid      = valid_q;
  assign o_allValid   = all_q;
  assign o_fault      = fault_q;
  assign o_windowTick = tick_q;

endmodule : multi_gate_watchdog
